// File: rtl/ctrl_bin_seq.sv
// ctrl_bin_seq: walks bins 0..num_bins-1 through load / core / store, backtracking on partial UNSAT.
// Define CTRL_BIN_SEQ_STATS_EN to add sat/unsat return counters and the max backtrack distance.
module ctrl_bin_seq #(
   parameter int unsigned              WIDTH_BIN_ID  = 10,
   parameter int unsigned              WIDTH_RUN_CNT = 32,
   parameter logic [WIDTH_RUN_CNT-1:0] MAX_CORE_RUNS = 32'hFFFF_FFFF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic [WIDTH_BIN_ID-1:0]  num_bins_i,
   output logic                     done_o,
   output logic                     global_sat_o,
   output logic                     global_unsat_o,
   output logic                     err_o,
   output logic                     timeout_o,
   output logic                     start_load_o,
   output logic [WIDTH_BIN_ID-1:0]  load_bin_id_o,
   input  logic                     done_load_i,
   output logic                     start_core_o,
   input  logic                     done_core_i,
   input  logic                     sat_i,
   input  logic                     unsat_i,
   input  logic [WIDTH_BIN_ID-1:0]  bkt_bin_num_i,
   output logic [WIDTH_BIN_ID-1:0]  cur_bin_num_o,
   output logic                     start_store_o,
   input  logic                     done_store_i,
   output logic [WIDTH_RUN_CNT-1:0] run_cnt_o
`ifdef CTRL_BIN_SEQ_STATS_EN
   ,
   output logic [WIDTH_RUN_CNT-1:0] sat_cnt_o,
   output logic [WIDTH_RUN_CNT-1:0] unsat_cnt_o,
   output logic [WIDTH_RUN_CNT-1:0] bkt_dist_max_o
`endif
);

   localparam logic [WIDTH_BIN_ID-1:0]  BKT_ROOT = '1;
   localparam logic [WIDTH_BIN_ID-1:0]  BIN_ONE  = {{(WIDTH_BIN_ID-1){1'b0}}, 1'b1};
   localparam logic [WIDTH_RUN_CNT-1:0] RUN_ONE  = {{(WIDTH_RUN_CNT-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_CORE, S_STORE_SAT, S_STORE_BKT,
      S_FIN_SAT, S_FIN_UNSAT, S_FIN_ERR, S_FIN_TO
   } state_t;

   state_t                   state_q, state_d;
   logic                     first_q;
   logic [WIDTH_BIN_ID-1:0]  cur_q, cur_d;
   logic [WIDTH_BIN_ID-1:0]  nb_q, nb_d;
   logic [WIDTH_BIN_ID-1:0]  bkt_q, bkt_d;
   logic [WIDTH_RUN_CNT-1:0] run_q, run_d;
   logic                     start_load_q, start_load_d;
   logic                     start_core_q, start_core_d;
   logic                     start_store_q, start_store_d;
   logic                     done_q, done_d;
   logic                     sat_q, sat_d, unsat_q, unsat_d, err_q, err_d, to_q, to_d;
   logic                     accept_start;
   logic                     core_ret;

   assign accept_start = (state_q == S_IDLE) && start_i;
   // Completions are only honoured after the request pulse has gone out (first cycle is the issue cycle).
   assign core_ret     = (state_q == S_CORE) && !first_q && done_core_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= (state_d != state_q);
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      nb_d    = nb_q;
      bkt_d   = bkt_q;
      run_d   = run_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cur_d   = '0;
               run_d   = '0;
               nb_d    = num_bins_i;
               state_d = (num_bins_i == '0) ? S_FIN_ERR : S_LOAD;
            end
         end
         S_LOAD: begin
            if (done_load_i && !first_q) state_d = S_CORE;
         end
         S_CORE: begin
            if (first_q) begin
               run_d = run_q + RUN_ONE;
            end else if (core_ret) begin
               if (run_q == MAX_CORE_RUNS) begin
                  state_d = S_FIN_TO;
               end else if (sat_i && !unsat_i) begin
                  state_d = S_STORE_SAT;
               end else if (unsat_i && !sat_i && bkt_bin_num_i == BKT_ROOT) begin
                  state_d = S_FIN_UNSAT;
               end else if (unsat_i && !sat_i && bkt_bin_num_i < cur_q) begin
                  state_d = S_STORE_BKT;
                  bkt_d   = bkt_bin_num_i;
               end else begin
                  state_d = S_FIN_ERR;
               end
            end
         end
         S_STORE_SAT: begin
            if (done_store_i && !first_q) begin
               if (cur_q == nb_q - BIN_ONE) begin
                  state_d = S_FIN_SAT;
               end else begin
                  cur_d   = cur_q + BIN_ONE;
                  state_d = S_LOAD;
               end
            end
         end
         S_STORE_BKT: begin
            if (done_store_i && !first_q) begin
               cur_d   = bkt_q;
               state_d = S_LOAD;
            end
         end
         S_FIN_SAT, S_FIN_UNSAT, S_FIN_ERR, S_FIN_TO: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_load_d  = (state_q == S_LOAD) && first_q;
      start_core_d  = (state_q == S_CORE) && first_q;
      start_store_d = ((state_q == S_STORE_SAT) || (state_q == S_STORE_BKT)) && first_q;
      done_d        = (state_q == S_FIN_SAT) || (state_q == S_FIN_UNSAT) ||
                      (state_q == S_FIN_ERR) || (state_q == S_FIN_TO);
      sat_d         = sat_q;
      unsat_d       = unsat_q;
      err_d         = err_q;
      to_d          = to_q;
      if (accept_start) begin
         sat_d   = 1'b0;
         unsat_d = 1'b0;
         err_d   = 1'b0;
         to_d    = 1'b0;
      end
      case (state_q)
         S_FIN_SAT:   sat_d = 1'b1;
         S_FIN_UNSAT: unsat_d = 1'b1;
         S_FIN_ERR: begin
            unsat_d = 1'b1;
            err_d   = 1'b1;
         end
         S_FIN_TO:    to_d = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_q         <= '0;
         nb_q          <= '0;
         bkt_q         <= '0;
         run_q         <= '0;
         start_load_q  <= 1'b0;
         start_core_q  <= 1'b0;
         start_store_q <= 1'b0;
         done_q        <= 1'b0;
         sat_q         <= 1'b0;
         unsat_q       <= 1'b0;
         err_q         <= 1'b0;
         to_q          <= 1'b0;
      end else begin
         cur_q         <= cur_d;
         nb_q          <= nb_d;
         bkt_q         <= bkt_d;
         run_q         <= run_d;
         start_load_q  <= start_load_d;
         start_core_q  <= start_core_d;
         start_store_q <= start_store_d;
         done_q        <= done_d;
         sat_q         <= sat_d;
         unsat_q       <= unsat_d;
         err_q         <= err_d;
         to_q          <= to_d;
      end
   end

   assign done_o         = done_q;
   assign global_sat_o   = sat_q;
   assign global_unsat_o = unsat_q;
   assign err_o          = err_q;
   assign timeout_o      = to_q;
   assign start_load_o   = start_load_q;
   assign load_bin_id_o  = cur_q;
   assign start_core_o   = start_core_q;
   assign cur_bin_num_o  = cur_q;
   assign start_store_o  = start_store_q;
   assign run_cnt_o      = run_q;

`ifdef CTRL_BIN_SEQ_STATS_EN
   logic [WIDTH_RUN_CNT-1:0] sat_cnt_q, sat_cnt_d;
   logic [WIDTH_RUN_CNT-1:0] unsat_cnt_q, unsat_cnt_d;
   logic [WIDTH_RUN_CNT-1:0] dist_max_q, dist_max_d;
   logic [WIDTH_RUN_CNT-1:0] dist_w;

   assign dist_w = WIDTH_RUN_CNT'(cur_q - bkt_bin_num_i);

   always_comb begin
      sat_cnt_d   = sat_cnt_q;
      unsat_cnt_d = unsat_cnt_q;
      dist_max_d  = dist_max_q;
      if (accept_start) begin
         sat_cnt_d   = '0;
         unsat_cnt_d = '0;
         dist_max_d  = '0;
      end else if (core_ret) begin
         if (sat_i && !unsat_i) sat_cnt_d = sat_cnt_q + RUN_ONE;
         if (unsat_i && !sat_i) begin
            unsat_cnt_d = unsat_cnt_q + RUN_ONE;
            if (bkt_bin_num_i < cur_q && dist_w > dist_max_q) dist_max_d = dist_w;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_cnt_q   <= '0;
         unsat_cnt_q <= '0;
         dist_max_q  <= '0;
      end else begin
         sat_cnt_q   <= sat_cnt_d;
         unsat_cnt_q <= unsat_cnt_d;
         dist_max_q  <= dist_max_d;
      end
   end

   assign sat_cnt_o      = sat_cnt_q;
   assign unsat_cnt_o    = unsat_cnt_q;
   assign bkt_dist_max_o = dist_max_q;
`endif

endmodule

// File: tb/tb_ctrl_bin_seq.sv
// Bench for ctrl_bin_seq: scripted core responses from a table, random scripts checked
// against a bin-walk reference model, plus hand sequences for reset and sticky flags.
module tb_ctrl_bin_seq;

   localparam int W     = 10;
   localparam int RC    = 32;
   localparam int ROOT  = 1023;
   localparam int NRESP = 64;
   localparam int K_SAT = 0, K_UNSAT = 1, K_BOTH = 2, K_NONE = 3;

   typedef struct {
      int    nb;
      int    sel;
      string resp;
      string loads;
      int    e_sat, e_unsat, e_err, e_to, e_runs, e_stores, inject;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic start_i;
   logic [W-1:0] num_bins_i, bkt_bin_num_i;
   logic done_load_i, done_core_i, sat_i, unsat_i, done_store_i;

   logic a_done, a_sat, a_unsat, a_err, a_to, a_sl, a_sc, a_ss;
   logic [W-1:0] a_lid, a_cur;
   logic [RC-1:0] a_run;
   logic b_done, b_sat, b_unsat, b_err, b_to, b_sl, b_sc, b_ss;
   logic [W-1:0] b_lid, b_cur;
   logic [RC-1:0] b_run;

   logic sel;
   logic s_done, s_sat, s_unsat, s_err, s_to, s_sl, s_sc, s_ss;
   logic [W-1:0] s_lid, s_cur;
   logic [RC-1:0] s_run;

   int checks, errors;
   int resp_kind [NRESP];
   int resp_bkt  [NRESP];
   int got_loads[$];
   int exp_loads[$];
   int e_sat, e_unsat, e_err, e_to, e_runs, e_stores;
   int n_core, n_store, fin_seen;
   int r_sat, r_unsat, r_err, r_to;
   logic [RC-1:0] r_run;
   vec_t tbl [13];

   always #5 clk = ~clk;

   ctrl_bin_seq #(.WIDTH_BIN_ID(W), .WIDTH_RUN_CNT(RC)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .num_bins_i(num_bins_i),
      .done_o(a_done), .global_sat_o(a_sat), .global_unsat_o(a_unsat), .err_o(a_err),
      .timeout_o(a_to), .start_load_o(a_sl), .load_bin_id_o(a_lid), .done_load_i(done_load_i),
      .start_core_o(a_sc), .done_core_i(done_core_i), .sat_i(sat_i), .unsat_i(unsat_i),
      .bkt_bin_num_i(bkt_bin_num_i), .cur_bin_num_o(a_cur), .start_store_o(a_ss),
      .done_store_i(done_store_i), .run_cnt_o(a_run));

   ctrl_bin_seq #(.WIDTH_BIN_ID(W), .WIDTH_RUN_CNT(RC), .MAX_CORE_RUNS(32'd2)) dut_to (
      .clk(clk), .rst(rst), .start_i(start_i), .num_bins_i(num_bins_i),
      .done_o(b_done), .global_sat_o(b_sat), .global_unsat_o(b_unsat), .err_o(b_err),
      .timeout_o(b_to), .start_load_o(b_sl), .load_bin_id_o(b_lid), .done_load_i(done_load_i),
      .start_core_o(b_sc), .done_core_i(done_core_i), .sat_i(sat_i), .unsat_i(unsat_i),
      .bkt_bin_num_i(bkt_bin_num_i), .cur_bin_num_o(b_cur), .start_store_o(b_ss),
      .done_store_i(done_store_i), .run_cnt_o(b_run));

   assign s_done  = sel ? b_done  : a_done;
   assign s_sat   = sel ? b_sat   : a_sat;
   assign s_unsat = sel ? b_unsat : a_unsat;
   assign s_err   = sel ? b_err   : a_err;
   assign s_to    = sel ? b_to    : a_to;
   assign s_sl    = sel ? b_sl    : a_sl;
   assign s_sc    = sel ? b_sc    : a_sc;
   assign s_ss    = sel ? b_ss    : a_ss;
   assign s_lid   = sel ? b_lid   : a_lid;
   assign s_cur   = sel ? b_cur   : a_cur;
   assign s_run   = sel ? b_run   : a_run;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      start_i = 1'b0; done_load_i = 1'b0; done_core_i = 1'b0; done_store_i = 1'b0;
      sat_i = 1'b0; unsat_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // 'S' sat, 'B' both flags, 'N' neither, 'R' unsat to root, digit = unsat with that backtrack bin
   task automatic load_script(input string s);
      for (int i = 0; i < NRESP; i++) begin
         resp_kind[i] = K_SAT;
         resp_bkt[i]  = 0;
         if (i < s.len()) begin
            if (s[i] == "B") resp_kind[i] = K_BOTH;
            else if (s[i] == "N") resp_kind[i] = K_NONE;
            else if (s[i] == "R") begin resp_kind[i] = K_UNSAT; resp_bkt[i] = ROOT; end
            else if (s[i] >= "0" && s[i] <= "9") begin
               resp_kind[i] = K_UNSAT;
               resp_bkt[i]  = int'(s[i]) - int'("0");
            end
         end
      end
   endtask

   // Reference: the bin walk expressed directly as a loop over core returns.
   task automatic model(input int nb, input longint maxr);
      int cur, runs, k, b;
      exp_loads.delete();
      e_sat = 0; e_unsat = 0; e_err = 0; e_to = 0; e_stores = 0; runs = 0; cur = 0;
      if (nb == 0) begin
         e_unsat = 1; e_err = 1;
      end else begin
         for (int g = 0; g < 100000; g++) begin
            exp_loads.push_back(cur);
            k = (runs < NRESP) ? resp_kind[runs] : K_SAT;
            b = (runs < NRESP) ? resp_bkt[runs] : 0;
            runs++;
            if (longint'(runs) == maxr) begin e_to = 1; break; end
            if (k == K_SAT) begin
               e_stores++;
               if (cur == nb - 1) begin e_sat = 1; break; end
               cur++;
            end else if (k == K_UNSAT && b == ROOT) begin
               e_unsat = 1; break;
            end else if (k == K_UNSAT && b < cur) begin
               e_stores++;
               cur = b;
            end else begin
               e_unsat = 1; e_err = 1; break;
            end
         end
      end
      e_runs = runs;
   endtask

   task automatic run_solve(input string tag, input int nb, input int inject);
      int lw, cw, sw, ri, k;
      lw = 0; cw = 0; sw = 0; ri = 0;
      got_loads.delete();
      n_core = 0; n_store = 0; fin_seen = 0;
      @(negedge clk);
      clear_inputs();
      start_i = 1'b1;
      num_bins_i = W'(nb);
      for (int cyc = 0; cyc < 3000 && fin_seen == 0; cyc++) begin
         @(negedge clk);
         clear_inputs();
         bkt_bin_num_i = W'($urandom);
         if (cyc == 0) begin
            check({tag, "_clr_flags"}, {s_sat, s_unsat, s_err, s_to}, 0);
            check({tag, "_clr_run"}, s_run, 0);
         end
         if (lw > 0) begin lw--; if (lw == 0) done_load_i = 1'b1; end
         if (sw > 0) begin sw--; if (sw == 0) done_store_i = 1'b1; end
         if (cw > 0) begin
            cw--;
            if (cw == 0) begin
               k = (ri < NRESP) ? resp_kind[ri] : K_SAT;
               done_core_i   = 1'b1;
               sat_i         = (k == K_SAT) || (k == K_BOTH);
               unsat_i       = (k == K_UNSAT) || (k == K_BOTH);
               bkt_bin_num_i = (ri < NRESP) ? W'(resp_bkt[ri]) : W'(0);
               ri++;
            end
         end
         if (s_sl) begin got_loads.push_back(int'(s_lid)); lw = $urandom_range(1, 3); end
         if (s_sc) begin n_core++; cw = $urandom_range(1, 3); end
         if (s_ss) begin n_store++; sw = $urandom_range(1, 3); end
         if (!done_load_i && lw == 0 && $urandom_range(0, 7) == 0) done_load_i = 1'b1;
         if (!done_store_i && sw == 0 && $urandom_range(0, 7) == 0) done_store_i = 1'b1;
         if (!done_core_i && cw == 0 && $urandom_range(0, 7) == 0) begin
            done_core_i = 1'b1;
            sat_i = 1'($urandom);
            unsat_i = 1'($urandom);
         end
         if (s_done) begin
            fin_seen = 1;
            r_sat = int'(s_sat); r_unsat = int'(s_unsat); r_err = int'(s_err); r_to = int'(s_to);
            r_run = s_run;
         end else if (inject != 0 && cyc == inject) begin
            start_i = 1'b1;
            num_bins_i = '0;
         end
      end
      @(negedge clk);
      clear_inputs();
      check({tag, "_done_width"}, s_done, 0);
   endtask

   task automatic compare(input string tag);
      check({tag, "_done"}, fin_seen, 1);
      check({tag, "_sat"}, r_sat, e_sat);
      check({tag, "_unsat"}, r_unsat, e_unsat);
      check({tag, "_err"}, r_err, e_err);
      check({tag, "_timeout"}, r_to, e_to);
      check({tag, "_run_cnt"}, r_run, e_runs);
      check({tag, "_core_pulses"}, n_core, e_runs);
      check({tag, "_store_pulses"}, n_store, e_stores);
      check({tag, "_nloads"}, got_loads.size(), exp_loads.size());
      for (int i = 0; i < got_loads.size() && i < exp_loads.size(); i++)
         check($sformatf("%s_load%0d", tag, i), got_loads[i], exp_loads[i]);
   endtask

   task automatic wait_for(input int which, input string nm);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         case (which)
            0:       seen = s_sl;
            1:       seen = s_sc;
            2:       seen = s_ss;
            default: seen = s_done;
         endcase
      end
      check(nm, seen, 1);
   endtask

   initial begin
      logic any;
      checks = 0; errors = 0; sel = 1'b0; rst = 1'b0;
      clear_inputs();
      num_bins_i = '0; bkt_bin_num_i = '0;

      tbl[0]  = '{3, 0, "SSS",    "012",    1, 0, 0, 0, 3, 3, 0};
      tbl[1]  = '{4, 0, "SS1SSS", "012123", 1, 0, 0, 0, 6, 6, 0};
      tbl[2]  = '{3, 0, "SR",     "01",     0, 1, 0, 0, 2, 1, 0};
      tbl[3]  = '{4, 0, "S3",     "01",     0, 1, 1, 0, 2, 1, 0};
      tbl[4]  = '{4, 0, "SS2",    "012",    0, 1, 1, 0, 3, 2, 0};
      tbl[5]  = '{3, 0, "SB",     "01",     0, 1, 1, 0, 2, 1, 0};
      tbl[6]  = '{3, 0, "N",      "0",      0, 1, 1, 0, 1, 0, 0};
      tbl[7]  = '{0, 0, "",       "",       0, 1, 1, 0, 0, 0, 0};
      tbl[8]  = '{1, 0, "S",      "0",      1, 0, 0, 0, 1, 1, 3};
      tbl[9]  = '{2, 0, "S0S0SS", "010101", 1, 0, 0, 0, 6, 6, 0};
      tbl[10] = '{3, 1, "S0",     "01",     0, 0, 0, 1, 2, 1, 0};
      tbl[11] = '{1, 1, "S",      "0",      1, 0, 0, 0, 1, 1, 0};
      tbl[12] = '{2, 1, "SS",     "01",     0, 0, 0, 1, 2, 1, 0};

      repeat (2) @(negedge clk);
      check("reset_outputs", {s_done, s_sat, s_unsat, s_err, s_to, s_sl, s_sc, s_ss, s_lid, s_cur, s_run}, 0);
      check("reset_outputs_to", {b_done, b_sat, b_unsat, b_err, b_to, b_sl, b_sc, b_ss, b_lid, b_cur, b_run}, 0);
      rst = 1'b1;

      for (int i = 0; i < 13; i++) begin
         if ((tbl[i].sel != 0) != sel) begin
            sel = (tbl[i].sel != 0);
            do_reset();
         end
         load_script(tbl[i].resp);
         e_sat = tbl[i].e_sat; e_unsat = tbl[i].e_unsat; e_err = tbl[i].e_err;
         e_to = tbl[i].e_to; e_runs = tbl[i].e_runs; e_stores = tbl[i].e_stores;
         exp_loads.delete();
         for (int j = 0; j < tbl[i].loads.len(); j++)
            exp_loads.push_back(int'(tbl[i].loads[j]) - int'("0"));
         run_solve($sformatf("v%0d", i), tbl[i].nb, tbl[i].inject);
         compare($sformatf("v%0d", i));
      end

      sel = 1'b0;
      do_reset();
      for (int r = 0; r < 25; r++) begin
         int nb, p;
         nb = $urandom_range(1, 6);
         for (int j = 0; j < NRESP; j++) begin
            p = $urandom_range(0, 99);
            resp_bkt[j] = 0;
            if (p < 70) resp_kind[j] = K_SAT;
            else if (p < 92) begin resp_kind[j] = K_UNSAT; resp_bkt[j] = $urandom_range(0, nb - 1); end
            else if (p < 96) begin resp_kind[j] = K_UNSAT; resp_bkt[j] = ROOT; end
            else if (p < 98) resp_kind[j] = K_BOTH;
            else resp_kind[j] = K_NONE;
         end
         model(nb, 64'hFFFF_FFFF);
         run_solve($sformatf("rnd%0d", r), nb, $urandom_range(2, 20));
         compare($sformatf("rnd%0d", r));
      end

      // Reset while a store is outstanding, then a late store completion.
      load_script("SSS");
      @(negedge clk);
      start_i = 1'b1; num_bins_i = W'(3);
      @(negedge clk);
      start_i = 1'b0;
      wait_for(0, "rst_seq_load");
      @(negedge clk); done_load_i = 1'b1;
      @(negedge clk); done_load_i = 1'b0;
      wait_for(1, "rst_seq_core");
      @(negedge clk); done_core_i = 1'b1; sat_i = 1'b1;
      @(negedge clk); done_core_i = 1'b0; sat_i = 1'b0;
      wait_for(2, "rst_seq_store");
      #2 rst = 1'b0;
      #1 check("rst_mid_outputs", {s_done, s_sat, s_unsat, s_err, s_to, s_sl, s_sc, s_ss, s_lid, s_cur}, 0);
      check("rst_mid_run", s_run, 0);
      @(negedge clk);
      rst = 1'b1; done_store_i = 1'b1;
      @(negedge clk);
      done_store_i = 1'b0;
      any = 1'b0;
      repeat (6) begin
         @(negedge clk);
         any = any | s_sl | s_sc | s_ss | s_done;
      end
      check("rst_no_pulses", any, 0);
      check("rst_cur_idle", s_cur, 0);
      model(3, 64'hFFFF_FFFF);
      run_solve("after_rst", 3, 0);
      compare("after_rst");

      repeat (3) @(negedge clk);
      check("sticky_sat_hold", s_sat, 1);
      check("sticky_done_low", s_done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_bin_seq.md
Name: ctrl_bin_seq

Overview:
Top-level bin sequencer that owns the start_core/done_core handshake of the per-bin sat engine controller.
- Walks bins 0..num_bins_i-1 in order: load bin, run the core, store the bin back.
- On a partial SAT it advances to the next bin; on a partial UNSAT it jumps back to the returned backtrack bin.
- Reports global SAT, global UNSAT, protocol error or run-limit timeout to the host.

Parameters:
WIDTH_BIN_ID, 10, width of bin index; all-ones value (BKT_ROOT) is reserved as the "backtrack past bin 0" sentinel
WIDTH_RUN_CNT, 32, width of core-run counter
MAX_CORE_RUNS, 32'hFFFF_FFFF, core runs allowed before timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start_i  in  1  1-cycle pulse from host, starts a solve
num_bins_i  in  WIDTH_BIN_ID  bin count, sampled on start_i, legal 1..BKT_ROOT-1
done_o  out  1  1-cycle pulse when solve ends
global_sat_o  out  1  sticky result flag
global_unsat_o  out  1  sticky result flag
err_o  out  1  sticky, illegal backtrack target
timeout_o  out  1  sticky, run limit hit
start_load_o  out  1  1-cycle pulse, load bin load_bin_id_o
load_bin_id_o  out  WIDTH_BIN_ID  bin to load, equals cur_bin_num_o
done_load_i  in  1  1-cycle pulse, load finished
start_core_o  out  1  1-cycle pulse to core controller
done_core_i  in  1  1-cycle pulse from core controller
sat_i  in  1  core partial SAT, valid with done_core_i
unsat_i  in  1  core partial UNSAT, valid with done_core_i
bkt_bin_num_i  in  WIDTH_BIN_ID  backtrack target, valid with done_core_i when unsat_i
cur_bin_num_o  out  WIDTH_BIN_ID  bin currently owned by the core
start_store_o  out  1  1-cycle pulse, write bin back
done_store_i  in  1  1-cycle pulse, store finished
run_cnt_o  out  WIDTH_RUN_CNT  core runs this solve

Behaviour:
- Reset (async, rst=0): state IDLE; every output 0.
- Registered FSM. Each start_*_o is issued as one pulse on the cycle after entering its state.
- States and transitions:
  - IDLE: start_i -> LOAD. On the same edge: cur_bin=0, run_cnt=0, flags cleared, num_bins latched.
  - LOAD: done_load_i -> CORE.
  - CORE: pulse start_core_o, run_cnt++. Then wait for done_core_i and decode:
    - sat_i -> STORE_SAT.
    - unsat_i with bkt==BKT_ROOT -> FIN_UNSAT.
    - unsat_i with bkt<cur -> STORE_BKT.
    - unsat_i with bkt>=cur, or sat_i and unsat_i both 1, or both 0 -> FIN_ERR.
  - STORE_SAT: done_store_i -> if cur==num_bins-1 then FIN_SAT, else cur++ and -> LOAD.
  - STORE_BKT: done_store_i -> cur=bkt (latched at done_core_i) and -> LOAD.
  - FIN_SAT / FIN_UNSAT / FIN_ERR / FIN_TO: set matching sticky flag(s), pulse done_o, -> IDLE.
    - FIN_UNSAT sets global_unsat_o.
    - FIN_ERR sets global_unsat_o and err_o.
- Timeout: when done_core_i arrives and run_cnt==MAX_CORE_RUNS, go -> FIN_TO regardless of result; timeout_o=1, both result flags 0.
- Done pulses arriving in a state that is not waiting for them are ignored.
- start_i outside IDLE is ignored.
- done_o rises exactly one cycle after entering a FIN state, then returns to 0.
- Sticky flags hold until the next accepted start_i.
- num_bins_i==0 at start: -> FIN_ERR immediately, no load issued.
- Reset mid-solve aborts at once: all outputs 0, no pulses until the next start_i.

Optional Feature:
CTRL_BIN_SEQ_STATS_EN:
- Defined: adds outputs sat_cnt_o, unsat_cnt_o and bkt_dist_max_o, all WIDTH_RUN_CNT wide, cleared on start_i.
  - sat_cnt_o counts partial SAT returns.
  - unsat_cnt_o counts partial UNSAT returns.
  - bkt_dist_max_o holds the largest cur-bkt seen.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- num_bins=3, core returns sat for every bin -> loads 0,1,2 in order, 3 core runs, done_o pulse, global_sat_o=1, run_cnt_o=3.
- num_bins=4; bin2 returns unsat with bkt=1, then all bins sat -> load order 0,1,2,1,2,3, global_sat_o=1, run_cnt_o=6.
- bin1 returns unsat with bkt=BKT_ROOT -> no store, global_unsat_o=1, err_o=0, done_o pulse.
- bin1 returns unsat with bkt=3 -> err_o=1, global_unsat_o=1.
- MAX_CORE_RUNS=2; bin1 unsat bkt=0 repeatedly -> timeout_o=1 after the 2nd done_core_i, sat/unsat flags 0.
- Reset asserted during STORE_SAT -> all outputs 0 immediately; a late done_store_i is ignored; a new start_i restarts from bin 0.
